// File: rtl/cache_pkg.sv
// Shared cache geometry and refill FSM encoding.
// Address/word width lives with the processor and is a parameter of the refill controller.
package cache_pkg;
  localparam int CACHE_LINE_SIZE = 128;
  localparam int LINE_BITS       = 2;
  localparam int OFFSET_BITS     = 4;
  localparam int TAG_BITS        = 26;  // 32-bit address minus index and offset

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESPOND   = 2'd3
  } refill_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] val;

  always_ff @(posedge clk) begin
    if (rst)                    val <= '0;
    else if (inc && val != '1)  val <= val + 1'b1;
  end

  assign cnt = val;
endmodule

// File: rtl/cache_refill_ctrl.sv
// L1 miss handler: optional dirty-victim writeback, line refill, one-cycle fill strobe.
// Pipeline stall covers the whole transaction; miss/writeback counters saturate.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ARCH_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       missReq,
  input  logic [ARCH_BITS-1:0]       missAddr,
  input  logic                       victimDirty,
  input  logic [TAG_BITS-1:0]        victimTag,
  input  logic [CACHE_LINE_SIZE-1:0] victimData,
  output logic                       stall,
  output logic                       fillValid,
  output logic [LINE_BITS-1:0]       fillLine,
  output logic [TAG_BITS-1:0]        fillTag,
  output logic [CACHE_LINE_SIZE-1:0] fillData,
  output logic                       memReq,
  output logic                       memWE,
  output logic [ARCH_BITS-1:0]       memAddr,
  output logic [CACHE_LINE_SIZE-1:0] memWData,
  input  logic                       memAck,
  input  logic [CACHE_LINE_SIZE-1:0] memRData,
  output logic [CNT_BITS-1:0]        missCount,
  output logic [CNT_BITS-1:0]        wbCount
);
  localparam logic [OFFSET_BITS-1:0] ZERO_OFF = '0;

  refill_state_t              state, stateNext;
  logic                       guard, guardNext;
  logic [TAG_BITS-1:0]        missTag, missTagNext;
  logic [LINE_BITS-1:0]       missLine, missLineNext;
  logic                       memReqNext, memWENext, fillValidNext;
  logic [ARCH_BITS-1:0]       memAddrNext;
  logic [CACHE_LINE_SIZE-1:0] memWDataNext, fillDataNext;
  logic [LINE_BITS-1:0]       fillLineNext;
  logic [TAG_BITS-1:0]        fillTagNext;
  logic                       missInc, wbInc;
  logic                       unusedOffset;

  assign unusedOffset = ^missAddr[OFFSET_BITS-1:0];
  // Combinational on missReq so the miss cycle itself already freezes the pipe.
  assign stall = missReq | (state != IDLE);

  always_comb begin
    stateNext     = state;
    guardNext     = 1'b0;
    missTagNext   = missTag;
    missLineNext  = missLine;
    memReqNext    = memReq;
    memWENext     = memWE;
    memAddrNext   = memAddr;
    memWDataNext  = memWData;
    fillValidNext = 1'b0;
    fillLineNext  = fillLine;
    fillTagNext   = fillTag;
    fillDataNext  = fillData;
    missInc       = 1'b0;
    wbInc         = 1'b0;
    case (state)
      IDLE: begin
        // guard: the cache has not yet seen the fill just issued, so missReq is stale
        if (missReq && !guard) begin
          missTagNext  = missAddr[ARCH_BITS-1 -: TAG_BITS];
          missLineNext = missAddr[OFFSET_BITS +: LINE_BITS];
          missInc      = 1'b1;
          memReqNext   = 1'b1;
          if (victimDirty) begin
            stateNext    = WRITEBACK;
            wbInc        = 1'b1;
            memWENext    = 1'b1;
            memAddrNext  = {victimTag, missLineNext, ZERO_OFF};
            memWDataNext = victimData;
          end else begin
            stateNext   = REFILL;
            memWENext   = 1'b0;
            memAddrNext = {missTagNext, missLineNext, ZERO_OFF};
          end
        end
      end
      WRITEBACK: if (memReq && memAck) begin
        stateNext   = REFILL;
        memWENext   = 1'b0;
        memAddrNext = {missTag, missLine, ZERO_OFF};
      end
      REFILL: if (memReq && memAck) begin
        stateNext     = RESPOND;
        memReqNext    = 1'b0;
        fillValidNext = 1'b1;
        fillLineNext  = missLine;
        fillTagNext   = missTag;
        fillDataNext  = memRData;
      end
      RESPOND: begin
        stateNext = IDLE;
        guardNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      guard     <= 1'b0;
      missTag   <= '0;
      missLine  <= '0;
      memReq    <= 1'b0;
      memWE     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      fillValid <= 1'b0;
      fillLine  <= '0;
      fillTag   <= '0;
      fillData  <= '0;
    end else begin
      state     <= stateNext;
      guard     <= guardNext;
      missTag   <= missTagNext;
      missLine  <= missLineNext;
      memReq    <= memReqNext;
      memWE     <= memWENext;
      memAddr   <= memAddrNext;
      memWData  <= memWDataNext;
      fillValid <= fillValidNext;
      fillLine  <= fillLineNext;
      fillTag   <= fillTagNext;
      fillData  <= fillDataNext;
    end
  end

  sat_counter #(.W(CNT_BITS)) uMissCnt (.clk(clk), .rst(rst), .inc(missInc), .cnt(missCount));
  sat_counter #(.W(CNT_BITS)) uWbCnt   (.clk(clk), .rst(rst), .inc(wbInc),   .cnt(wbCount));
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: clean/dirty misses, reset abort, guard, back-to-back, saturation.
module tb_cache_refill_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         missReq;
  logic [31:0]  missAddr;
  logic         victimDirty;
  logic [25:0]  victimTag;
  logic [127:0] victimData;
  logic         stall, fillValid, memReq, memWE, memAck;
  logic [1:0]   fillLine;
  logic [25:0]  fillTag;
  logic [127:0] fillData, memWData, memRData;
  logic [31:0]  memAddr;
  logic [15:0]  missCount, wbCount;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .missReq(missReq), .missAddr(missAddr),
    .victimDirty(victimDirty), .victimTag(victimTag), .victimData(victimData),
    .stall(stall), .fillValid(fillValid), .fillLine(fillLine), .fillTag(fillTag),
    .fillData(fillData), .memReq(memReq), .memWE(memWE), .memAddr(memAddr),
    .memWData(memWData), .memAck(memAck), .memRData(memRData),
    .missCount(missCount), .wbCount(wbCount)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle point: 2 time units after the rising edge; inputs change here, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Clean miss with a memory that acks in the first request cycle.
  task automatic doMiss(input logic [31:0] a, input logic [25:0] expTag, input logic [1:0] expLine,
                        input logic [127:0] d);
    missAddr = a; victimDirty = 1'b0; missReq = 1'b1;
    #1 chk("bb_stall_miss", stall, 1'b1);
    tick(); memAck = 1'b1; memRData = d;
    #1 chk("bb_memReq", memReq, 1'b1);
    chk("bb_memAddr", memAddr, {a[31:4], 4'h0});
    chk("bb_stall_req", stall, 1'b1);
    tick(); memAck = 1'b0;
    #1 chk("bb_fillValid", fillValid, 1'b1);
    chk("bb_fillLine", fillLine, expLine);
    chk("bb_fillTag", fillTag, expTag);
    chk("bb_fillData", fillData, d);
    chk("bb_stall_fill", stall, 1'b1);
    tick(); missReq = 1'b0;
    #1 chk("bb_fill_done", fillValid, 1'b0);
    chk("bb_stall_low", stall, 1'b0);
  endtask

  initial begin
    rst = 1'b1; missReq = 1'b0; missAddr = '0; victimDirty = 1'b0; victimTag = '0;
    victimData = '0; memAck = 1'b0; memRData = '0;
    tick(); tick(); rst = 1'b0;
    #1 chk("rst_stall", stall, 1'b0);
    chk("rst_memReq", memReq, 1'b0);
    chk("rst_memWE", memWE, 1'b0);
    chk("rst_fillValid", fillValid, 1'b0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_fillData", fillData, 128'h0);
    chk("rst_missCount", missCount, 16'h0);
    chk("rst_wbCount", wbCount, 16'h0);

    // 1: clean miss, ack after 3 request cycles
    tick(); missAddr = 32'h0000_1234; victimDirty = 1'b0; victimTag = 26'h3ff; missReq = 1'b1;
    #1 chk("t1_stall_miss", stall, 1'b1);
    chk("t1_noReq_yet", memReq, 1'b0);
    tick();
    #1 chk("t1_memReq", memReq, 1'b1);
    chk("t1_memWE", memWE, 1'b0);
    chk("t1_memAddr", memAddr, 32'h0000_1230);
    tick();
    #1 chk("t1_memReq_hold", memReq, 1'b1);
    tick(); memAck = 1'b1; memRData = {16{8'hA5}};
    #1 chk("t1_noFill_early", fillValid, 1'b0);
    tick(); memAck = 1'b0;
    #1 chk("t1_fillValid", fillValid, 1'b1);
    chk("t1_fillLine", fillLine, 2'd3);
    chk("t1_fillTag", fillTag, 26'h48);
    chk("t1_fillData", fillData, {16{8'hA5}});
    chk("t1_memReq_drop", memReq, 1'b0);
    chk("t1_stall_fill", stall, 1'b1);
    tick(); missReq = 1'b0;
    #1 chk("t1_fill_1cyc", fillValid, 1'b0);
    chk("t1_stall_low", stall, 1'b0);
    chk("t1_missCount", missCount, 16'd1);
    chk("t1_wbCount", wbCount, 16'd0);

    // 2: dirty miss, writeback then refill
    tick(); missAddr = 32'h0000_0010; victimDirty = 1'b1; victimTag = 26'h40;
    victimData = {8{16'hDEAD}}; missReq = 1'b1;
    tick(); victimData = '0; victimDirty = 1'b0;
    #1 chk("t2_wb_req", memReq, 1'b1);
    chk("t2_wb_we", memWE, 1'b1);
    chk("t2_wb_addr", memAddr, 32'h0000_1010);
    chk("t2_wb_data", memWData, {8{16'hDEAD}});
    chk("t2_wbCount", wbCount, 16'd1);
    chk("t2_missCount", missCount, 16'd2);
    memAck = 1'b1;
    tick(); memAck = 1'b0;
    #1 chk("t2_rd_req", memReq, 1'b1);
    chk("t2_rd_we", memWE, 1'b0);
    chk("t2_rd_addr", memAddr, 32'h0000_0010);
    memAck = 1'b1; memRData = {4{32'h1234_5678}};
    tick(); memAck = 1'b0;
    #1 chk("t2_fillValid", fillValid, 1'b1);
    chk("t2_fillLine", fillLine, 2'd1);
    chk("t2_fillTag", fillTag, 26'h0);
    chk("t2_fillData", fillData, {4{32'h1234_5678}});
    missReq = 1'b0;
    tick();
    #1 chk("t2_stall_low", stall, 1'b0);
    chk("t2_wbCount_end", wbCount, 16'd1);

    // 3: reset while waiting in REFILL
    tick(); missAddr = 32'h0000_2000; victimDirty = 1'b0; missReq = 1'b1;
    tick();
    #1 chk("t3_memReq", memReq, 1'b1);
    tick(); rst = 1'b1; missReq = 1'b0;
    tick();
    #1 chk("t3_memReq_drop", memReq, 1'b0);
    chk("t3_noFill", fillValid, 1'b0);
    chk("t3_missCount", missCount, 16'd0);
    chk("t3_wbCount", wbCount, 16'd0);
    rst = 1'b0; memAck = 1'b1;
    tick(); memAck = 1'b0;
    #1 chk("t3_stall_low", stall, 1'b0);
    chk("t3_noFill_after", fillValid, 1'b0);
    chk("t3_idle_noReq", memReq, 1'b0);

    // 4: spurious ack in IDLE, missReq held through RESPOND
    tick(); memAck = 1'b1;
    tick(); memAck = 1'b0;
    #1 chk("t4_spur_noReq", memReq, 1'b0);
    chk("t4_spur_noFill", fillValid, 1'b0);
    missAddr = 32'h0000_0100; missReq = 1'b1;
    tick(); memAck = 1'b1; memRData = {2{64'hCAFE_F00D_0BAD_BEEF}};
    #1 chk("t4_memReq", memReq, 1'b1);
    tick(); memAck = 1'b0;
    #1 chk("t4_fillValid", fillValid, 1'b1);
    chk("t4_fillTag", fillTag, 26'h4);
    tick();
    #1 chk("t4_guard_noReq", memReq, 1'b0);
    chk("t4_guard_stall", stall, 1'b1);
    missReq = 1'b0;
    tick();
    #1 chk("t4_still_idle", memReq, 1'b0);
    chk("t4_missCount", missCount, 16'd1);
    chk("t4_stall_low", stall, 1'b0);

    // 5: back-to-back misses to lines 0..3
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); doMiss(32'h0000_3000, 26'hC0, 2'd0, {4{32'h0000_0000}});
    tick(); doMiss(32'h0000_3010, 26'hC0, 2'd1, {4{32'h1111_1111}});
    tick(); doMiss(32'h0000_3020, 26'hC0, 2'd2, {4{32'h2222_2222}});
    tick(); doMiss(32'h0000_3030, 26'hC0, 2'd3, {4{32'h3333_3333}});
    #1 chk("t5_missCount", missCount, 16'd4);

    // 6: saturation
    tick();
    force dut.uMissCnt.val = 16'hFFFE;
    tick();
    release dut.uMissCnt.val;
    #1 chk("t6_preload", missCount, 16'hFFFE);
    tick(); doMiss(32'h0000_0040, 26'h1, 2'd0, {4{32'hAAAA_5555}});
    #1 chk("t6_reach_max", missCount, 16'hFFFF);
    tick(); doMiss(32'h0000_0050, 26'h1, 2'd1, {4{32'h5555_AAAA}});
    tick(); doMiss(32'h0000_0060, 26'h1, 2'd2, {4{32'h0F0F_F0F0}});
    #1 chk("t6_saturated", missCount, 16'hFFFF);
    chk("t6_wbCount", wbCount, 16'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
